// File: rtl/block_drop_controller_if.sv
// Control bundle between the stacking-game sequencer and its datapath/buttons.
// The sequencer is the slave side; whatever drives buttons and datapath flags is the master.
interface block_drop_controller_if;
   logic       start;
   logic       drop;
   logic       tick;
   logic       o;
   logic       c;
   logic       enable;
   logic       ld_x;
   logic       ld_y;
   logic       ld_d;
   logic       save_x;
   logic       inc_score;
   logic       dec_chances;
   logic       new_direction;
   logic [7:0] new_x_position;
   logic [6:0] new_y_position;
   logic       game_over;
   logic       won;
   logic [3:0] state;

   modport master (
      output start, drop, tick, o, c,
      input  enable, ld_x, ld_y, ld_d, save_x, inc_score, dec_chances,
      input  new_direction, new_x_position, new_y_position, game_over, won, state
   );

   modport slave (
      input  start, drop, tick, o, c,
      output enable, ld_x, ld_y, ld_d, save_x, inc_score, dec_chances,
      output new_direction, new_x_position, new_y_position, game_over, won, state
   );
endinterface

// File: rtl/block_drop_controller.sv
// Stacking-game sequencer: spawn, move, settle, judge per block; strobes are registered off the next state.
// Only enable is combinational (follows tick in MOVE); button edges not consumed by the current state are dropped.
module block_drop_controller #(
   parameter logic [7:0] SPAWN_X = 8'd0,
   parameter logic [6:0] START_Y = 7'd112,
   parameter logic [6:0] BLOCK_H = 7'd4,
   parameter logic [6:0] TOP_Y   = 7'd8
) (
   input  logic                  clk,
   input  logic                  reset,
   block_drop_controller_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      SPAWN  = 4'd1,
      MOVE   = 4'd2,
      SETTLE = 4'd3,
      JUDGE  = 4'd4,
      HIT    = 4'd5,
      MISS   = 4'd6,
      RECHK  = 4'd7,
      OVER   = 4'd8
   } state_t;

   state_t     cur;
   state_t     nxt;
   logic       start_q;
   logic       drop_q;
   logic       first_blk;
   logic       dir;
   logic       won_r;
   logic       ld_r;
   logic       save_r;
   logic       dec_r;
   logic       over_r;
   logic [6:0] y;
   logic [6:0] y_after_hit;
   logic       start_edge;
   logic       drop_edge;
   logic       top_reached;

   assign start_edge  = bus.start & ~start_q;
   assign drop_edge   = bus.drop & ~drop_q;
   assign y_after_hit = y - BLOCK_H;
   // A stack that would wrap below row 0 counts as reaching the top as well.
   assign top_reached = (y < BLOCK_H) || (y_after_hit < TOP_Y);

   always_comb begin
      nxt = IDLE;
      case (cur)
         IDLE:    nxt = start_edge ? SPAWN : IDLE;
         SPAWN:   nxt = MOVE;
         MOVE:    nxt = drop_edge ? SETTLE : MOVE;
         SETTLE:  nxt = JUDGE;
         JUDGE:   nxt = (first_blk || bus.o) ? HIT : MISS;
         HIT:     nxt = top_reached ? OVER : SPAWN;
         MISS:    nxt = RECHK;
         RECHK:   nxt = bus.c ? SPAWN : OVER;
         OVER:    nxt = OVER;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      start_q <= bus.start;
      drop_q  <= bus.drop;
      if (reset) begin
         cur       <= IDLE;
         y         <= START_Y;
         dir       <= 1'b0;
         first_blk <= 1'b1;
         won_r     <= 1'b0;
         ld_r      <= 1'b0;
         save_r    <= 1'b0;
         dec_r     <= 1'b0;
         over_r    <= 1'b0;
      end else begin
         cur    <= nxt;
         ld_r   <= (nxt == SPAWN);
         save_r <= (nxt == HIT);
         dec_r  <= (nxt == MISS);
         over_r <= (nxt == OVER);
         if (cur == SPAWN) begin
            dir <= ~dir;
         end
         // won only matters once OVER is reached; a miss path never sets it.
         if (cur == HIT) begin
            y         <= y_after_hit;
            first_blk <= 1'b0;
            won_r     <= top_reached;
         end
      end
   end

   assign bus.enable         = (cur == MOVE) && bus.tick && !drop_edge;
   assign bus.ld_x           = ld_r;
   assign bus.ld_y           = ld_r;
   assign bus.ld_d           = ld_r;
   assign bus.save_x         = save_r;
   assign bus.inc_score      = save_r;
   assign bus.dec_chances    = dec_r;
   assign bus.new_direction  = dir;
   assign bus.new_x_position = SPAWN_X;
   assign bus.new_y_position = y;
   assign bus.game_over      = over_r;
   assign bus.won            = won_r;
   assign bus.state          = cur;
endmodule
